// File: rtl/replacement_unit_v2.sv
// replacement_unit_v2: per-set victim selection (tree-PLRU, round-robin, LFSR).
// In: clk, rst_n, req_* query, upd_* hit/fill notify. Out: replace, replace_valid (1-cycle).
module replacement_unit_v2 #(
  parameter int          S    = 17,
  parameter int          B    = 9,
  parameter int          a    = 2,
  parameter int          MODE = 0,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [S-a-B-1:0]      req_set,
  input  logic [(1<<a)-1:0]     req_way_valid,
  output logic [a-1:0]          replace,
  output logic                  replace_valid,
  input  logic                  upd_valid,
  input  logic [S-a-B-1:0]      upd_set,
  input  logic [a-1:0]          upd_way,
  input  logic                  upd_fill
);

  localparam int SET_W = S - a - B;
  localparam int NSETS = 1 << SET_W;
  localparam int WAYS  = 1 << a;

  function automatic logic [a-1:0] first_invalid(
    input logic [WAYS-1:0] v
  );
    logic [a-1:0] w;
    w = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (!v[i]) w = a'(i);
    return w;
  endfunction

  // Tree held WAYS bits wide (top bit always 0) so
  // a node index always fits in a bits.
  function automatic logic [WAYS-1:0] plru_touch(
    input logic [WAYS-1:0] t,
    input logic [a-1:0]    way
  );
    logic [a-1:0] n;
    logic         b;
    n = '0;
    for (int l = 0; l < a; l++) begin
      b    = way[a-1-l];
      t[n] = ~b;
      n    = a'({n, 1'b1} + {{a{1'b0}}, b});
    end
    return t;
  endfunction

  function automatic logic [a-1:0] plru_victim(
    input logic [WAYS-1:0] t
  );
    logic [a-1:0] n;
    logic [a-1:0] w;
    logic         b;
    n = '0;
    w = '0;
    for (int l = 0; l < a; l++) begin
      b          = t[n];
      w[a-1-l]   = b;
      n          = a'({n, 1'b1} + {{a{1'b0}}, b});
    end
    return w;
  endfunction

  logic [a-1:0] pol;

  if (MODE == 0) begin : g_plru
    logic [WAYS-1:0] tree [NSETS];
    logic [WAYS-1:0] cur;

    // Same-set update this cycle is bypassed into the query.
    always_comb begin
      cur = tree[req_set];
      if (upd_valid && upd_set == req_set)
        cur = plru_touch(cur, upd_way);
    end

    assign pol = plru_victim(cur);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NSETS; i++)
          tree[i] <= '0;
      end else if (upd_valid) begin
        tree[upd_set] <= plru_touch(tree[upd_set], upd_way);
      end
    end
  end else if (MODE == 1) begin : g_rr
    logic [a-1:0] cnt [NSETS];
    logic         bump;

    assign bump = upd_valid && upd_fill && upd_set == req_set;
    assign pol  = cnt[req_set] + a'(bump);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NSETS; i++)
          cnt[i] <= '0;
      end else if (upd_valid && upd_fill) begin
        cnt[upd_set] <= cnt[upd_set] + 1'b1;
      end
    end
  end else begin : g_lfsr
    logic [15:0] lfsr;

    assign pol = lfsr[a-1:0];

    // x^16+x^14+x^13+x^11+1, maximal length.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        lfsr <= SEED;
      else
        lfsr <= {lfsr[14:0],
                 lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  logic unused;
  assign unused = ^{upd_fill, upd_way, upd_set,
                    upd_valid, req_set};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replace       <= '0;
      replace_valid <= 1'b0;
    end else begin
      replace_valid <= req_valid;
      if (req_valid)
        replace <= (&req_way_valid) ? pol
                 : first_invalid(req_way_valid);
    end
  end

endmodule
